// File: rtl/ifu_refill_unit.sv
// ifu_refill_unit: miss-refill engine between ifu_cache and instruction memory.
// Latches the missing tag and issues one burst read for the line-aligned
// address. It collects BEATS bus-wide beats into one line and returns
// {tag, line, valid} to the cache. Only one refill is in flight at a time.
// Optional feature: define IFU_REFILL_TIMEOUT_EN to abandon a refill when no
// beat arrives for TIMEOUT_CYCLES cycles in DATA. errTimeoutOut then pulses.
module ifu_refill_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int OFFSET_WIDTH   = 4,
  parameter int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH,
  parameter int LINE_WIDTH     = 128,
  parameter int BUS_WIDTH      = 32,
  parameter int BEATS          = LINE_WIDTH / BUS_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
  input  logic                  cache_reqValidIn,
  output logic [TAG_WIDTH-1:0]  cache_rspTagOut,
  output logic [LINE_WIDTH-1:0] cache_rspLineOut,
  output logic                  cache_rspValidOut,
  output logic                  mem_reqValidOut,
  output logic [ADDR_WIDTH-1:0] mem_reqAddrOut,
  input  logic                  mem_reqReadyIn,
  input  logic                  mem_rspValidIn,
  input  logic [BUS_WIDTH-1:0]  mem_rspDataIn,
  output logic                  busyOut,
  output logic                  errTimeoutOut
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_RESP,
    ST_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] rsp_line_q, rsp_line_d;
  logic [LINE_WIDTH-1:0] beat_line;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_hit;

`ifdef IFU_REFILL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Count beat-less DATA cycles. Any other state holds the counter at zero,
  // so it is already clear when DATA is entered.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_DATA && !mem_rspValidIn && !timeout_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign timeout_hit   = (state_q == ST_DATA) && !mem_rspValidIn && (tmo_q == TMO_LIMIT);
  assign errTimeoutOut = timeout_hit;

  // Timeout counter register.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign timeout_hit   = 1'b0;
  assign errTimeoutOut = 1'b0;
`endif

  // Next state. Holds the tag, assembles beats and captures the response.
  always_comb begin
    // NOTE: every target gets a default first, so no path leaves it unassigned (no latch).
    state_d    = state_q;
    tag_d      = tag_q;
    line_d     = line_q;
    cnt_d      = cnt_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_line_d = rsp_line_q;
    beat_line  = line_q;
    beat_line[int'(cnt_q) * BUS_WIDTH +: BUS_WIDTH] = mem_rspDataIn;

    unique case (state_q)
      ST_IDLE: begin
        if (cache_reqValidIn) begin
          tag_d   = cache_reqTagIn;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_reqReadyIn) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (timeout_hit) begin
          // Discard the partial line. No response is produced.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (mem_rspValidIn) begin
          line_d = beat_line;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d      = '0;
            rsp_line_d = beat_line;
            rsp_tag_d  = tag_q;
            state_d    = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_HOLD;
      // The cache's registered line insertion settles here, so a request is ignored.
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. All are cleared by reset, and reset abandons any refill.
  always_ff @(posedge Clock or posedge Rst) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (Rst) begin
      state_q    <= ST_IDLE;
      tag_q      <= '0;
      rsp_tag_q  <= '0;
      cnt_q      <= '0;
      // NOTE: the line buffers are reset because cache_rspLineOut must read 0 after reset.
      line_q     <= '0;
      rsp_line_q <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      rsp_tag_q  <= rsp_tag_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      rsp_line_q <= rsp_line_d;
    end
  end

  assign mem_reqValidOut   = (state_q == ST_REQ);
  assign mem_reqAddrOut    = {tag_q, {OFFSET_WIDTH{1'b0}}};
  assign cache_rspValidOut = (state_q == ST_RESP);
  assign cache_rspTagOut   = rsp_tag_q;
  assign cache_rspLineOut  = rsp_line_q;
  assign busyOut           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ifu_refill_unit.sv
// tb_ifu_refill_unit: self-checking bench for ifu_refill_unit.
// A transaction-level reference gives the expected line from the beat list.
// Expected latency is 2 + stall cycles + BEATS * (gap + 1).
module tb_ifu_refill_unit;

  logic          Clock;
  logic          Rst;
  logic [27:0]   cache_reqTagIn;
  logic          cache_reqValidIn;
  logic [27:0]   cache_rspTagOut;
  logic [127:0]  cache_rspLineOut;
  logic          cache_rspValidOut;
  logic          mem_reqValidOut;
  logic [31:0]   mem_reqAddrOut;
  logic          mem_reqReadyIn;
  logic          mem_rspValidIn;
  logic [31:0]   mem_rspDataIn;
  logic          busyOut;
  logic          errTimeoutOut;

  int n_tests = 0;
  int n_fail  = 0;

  ifu_refill_unit #(.TIMEOUT_CYCLES(8)) dut (
    .Clock             (Clock),
    .Rst               (Rst),
    .cache_reqTagIn    (cache_reqTagIn),
    .cache_reqValidIn  (cache_reqValidIn),
    .cache_rspTagOut   (cache_rspTagOut),
    .cache_rspLineOut  (cache_rspLineOut),
    .cache_rspValidOut (cache_rspValidOut),
    .mem_reqValidOut   (mem_reqValidOut),
    .mem_reqAddrOut    (mem_reqAddrOut),
    .mem_reqReadyIn    (mem_reqReadyIn),
    .mem_rspValidIn    (mem_rspValidIn),
    .mem_rspDataIn     (mem_rspDataIn),
    .busyOut           (busyOut),
    .errTimeoutOut     (errTimeoutOut)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance one cycle. Outputs are sampled and inputs are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One complete refill. The memory model stalls ready for rw cycles and leaves
  // gap idle cycles before each beat. The optional redirect changes the tag mid-burst.
  // The cache model holds its request until it has seen the response.
  task automatic run_refill(input logic [27:0] tag, input logic [127:0] line,
                            input int rw, input int gap,
                            input bit redirect, input logic [27:0] redirect_tag,
                            input bit stray);
    int cyc;
    int exp_lat;
    exp_lat = 2 + rw + 4 * (gap + 1);
    cache_reqTagIn   = tag;
    cache_reqValidIn = 1'b1;
    mem_reqReadyIn   = 1'b0;
    cyc = 0;
    tick(); cyc++;
    check("req_valid", 128'(mem_reqValidOut), 128'(1'b1));
    check("req_addr", 128'(mem_reqAddrOut), 128'({tag, 4'h0}));
    for (int i = 0; i < rw; i++) begin
      mem_rspValidIn = stray;
      mem_rspDataIn  = $urandom;
      tick(); cyc++;
      check("req_stall_hold", 128'({mem_reqValidOut, mem_reqAddrOut}), 128'({1'b1, tag, 4'h0}));
    end
    mem_rspValidIn = 1'b0;
    mem_reqReadyIn = 1'b1;
    tick(); cyc++;
    mem_reqReadyIn = 1'b0;
    check("req_drop", 128'(mem_reqValidOut), 128'(1'b0));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rspValidIn = 1'b0;
        mem_rspDataIn  = $urandom;
        tick(); cyc++;
        check("no_early_rsp", 128'(cache_rspValidOut), 128'(1'b0));
      end
      mem_rspValidIn = 1'b1;
      mem_rspDataIn  = line[b*32 +: 32];
      if (redirect && b == 1) cache_reqTagIn = redirect_tag;
      tick(); cyc++;
      if (b < 3) check("no_early_rsp", 128'(cache_rspValidOut), 128'(1'b0));
    end
    mem_rspValidIn = 1'b0;
    mem_rspDataIn  = $urandom;
    for (int w = 0; w < 20 && !cache_rspValidOut; w++) begin
      tick(); cyc++;
    end
    check("rsp_valid", 128'(cache_rspValidOut), 128'(1'b1));
    check("rsp_latency", 128'(cyc), 128'(exp_lat));
    check("rsp_line", cache_rspLineOut, line);
    check("rsp_tag", 128'(cache_rspTagOut), 128'(tag));
    // The request stays high here. The unit must ignore it in HOLD.
    tick();
    check("hold_state", 128'({cache_rspValidOut, mem_reqValidOut, busyOut}), 128'(3'b001));
    cache_reqValidIn = 1'b0;
    tick();
    check("back_to_idle", 128'({busyOut, mem_reqValidOut}), 128'(2'b00));
    check("rsp_line_kept", cache_rspLineOut, line);
    check("rsp_tag_kept", 128'(cache_rspTagOut), 128'(tag));
  endtask

  initial begin
    logic [127:0] line;
    logic [27:0]  tag;
    bit           err_seen;
    bit           rsp_seen;
    int           err_cnt;

    Rst = 1'b1;
    cache_reqTagIn   = '0;
    cache_reqValidIn = 1'b0;
    mem_reqReadyIn   = 1'b0;
    mem_rspValidIn   = 1'b0;
    mem_rspDataIn    = '0;
    tick();
    tick();
    Rst = 1'b0;

    // Idle after reset: every output stays 0.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ctl", 128'({cache_rspValidOut, mem_reqValidOut, busyOut, errTimeoutOut}), 128'(4'b0));
    end
    check("idle_addr", 128'(mem_reqAddrOut), 128'(0));
    check("idle_line", cache_rspLineOut, 128'(0));
    check("idle_tag", 128'(cache_rspTagOut), 128'(0));

    // Basic refill with no stalls and back-to-back beats.
    run_refill(28'h0000123, 128'h44444444_33333333_22222222_11111111, 0, 0, 1'b0, 28'h0, 1'b0);
    // The request is not accepted for 3 cycles.
    run_refill(28'h0000123, 128'h44444444_33333333_22222222_11111111, 3, 0, 1'b0, 28'h0, 1'b1);
    // Two idle cycles between beats.
    run_refill(28'h0abcdef, 128'hdeadbeef_cafef00d_01234567_89abcdef, 0, 2, 1'b0, 28'h0, 1'b0);
    // Redirect to tag 0x456 mid-burst. The original tag is returned.
    run_refill(28'h0000123, 128'h0f0f0f0f_a5a5a5a5_5a5a5a5a_f0f0f0f0, 0, 0, 1'b1, 28'h0000456, 1'b0);
    run_refill(28'h0000456, 128'h12345678_9abcdef0_0fedcba9_87654321, 0, 0, 1'b0, 28'h0, 1'b0);

    // Reset after beat 2. Outputs clear at once and a late beat is ignored.
    cache_reqTagIn   = 28'h0000777;
    cache_reqValidIn = 1'b1;
    tick();
    mem_reqReadyIn = 1'b1;
    tick();
    mem_reqReadyIn = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rspValidIn = 1'b1;
      mem_rspDataIn  = 32'h77770000 + 32'(b);
      tick();
    end
    mem_rspValidIn   = 1'b0;
    cache_reqValidIn = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check("rst_ctl", 128'({cache_rspValidOut, mem_reqValidOut, busyOut, errTimeoutOut}), 128'(4'b0));
    check("rst_addr", 128'(mem_reqAddrOut), 128'(0));
    check("rst_line", cache_rspLineOut, 128'(0));
    check("rst_tag", 128'(cache_rspTagOut), 128'(0));
    #2 Rst = 1'b0;
    mem_rspValidIn = 1'b1;
    mem_rspDataIn  = 32'h77770003;
    tick();
    mem_rspValidIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_late_beat", 128'({cache_rspValidOut, busyOut}), 128'(2'b00));
      tick();
    end

`ifdef IFU_REFILL_TIMEOUT_EN
    // Beat 3 is withheld. Expect one timeout pulse and no response.
    cache_reqTagIn   = 28'h0000999;
    cache_reqValidIn = 1'b1;
    tick();
    cache_reqValidIn = 1'b0;
    mem_reqReadyIn   = 1'b1;
    tick();
    mem_reqReadyIn = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rspValidIn = 1'b1;
      mem_rspDataIn  = $urandom;
      tick();
    end
    mem_rspValidIn = 1'b0;
    err_seen = 1'b0;
    rsp_seen = 1'b0;
    err_cnt  = 0;
    for (int w = 0; w < 40; w++) begin
      if (errTimeoutOut) begin
        err_seen = 1'b1;
        err_cnt++;
      end
      if (cache_rspValidOut) rsp_seen = 1'b1;
      tick();
    end
    check("tmo_pulse", 128'(err_seen), 128'(1'b1));
    check("tmo_width", 128'(err_cnt), 128'(1));
    check("tmo_no_rsp", 128'(rsp_seen), 128'(1'b0));
    check("tmo_idle", 128'(busyOut), 128'(1'b0));
    mem_rspValidIn = 1'b1;
    tick();
    mem_rspValidIn = 1'b0;
    check("tmo_late_beat", 128'({cache_rspValidOut, busyOut}), 128'(2'b00));
`else
    err_seen = 1'b0;
    rsp_seen = 1'b0;
    err_cnt  = 0;
`endif

    // Random refills: random tags, data, request stalls, beat gaps and stray beats.
    for (int n = 0; n < 25; n++) begin
      tag  = 28'($urandom);
      line = {$urandom, $urandom, $urandom, $urandom};
      // A stray beat while idle must not disturb anything.
      mem_rspValidIn = 1'b1;
      mem_rspDataIn  = $urandom;
      tick();
      mem_rspValidIn = 1'b0;
      check("idle_stray", 128'({cache_rspValidOut, busyOut}), 128'(2'b00));
      run_refill(tag, line, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), 28'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
